// File: rtl/door_lock_pkg.sv
// rtl/door_lock_pkg.sv - state encoding, key constants and helpers for the door lock
package door_lock_pkg;

   localparam logic [2:0] STATE_LOCKED = 3'b000;
   localparam logic [2:0] STATE_DIG1   = 3'b001;
   localparam logic [2:0] STATE_DIG2   = 3'b010;
   localparam logic [2:0] STATE_DIG3   = 3'b011;
   localparam logic [2:0] STATE_OPEN   = 3'b100;
   localparam logic [2:0] STATE_ERROR  = 3'b101;

   localparam logic [3:0] KEY_CLEAR = 4'hA;

   typedef enum logic [2:0] {
      ST_LOCKED = STATE_LOCKED,
      ST_DIG1   = STATE_DIG1,
      ST_DIG2   = STATE_DIG2,
      ST_DIG3   = STATE_DIG3,
      ST_OPEN   = STATE_OPEN,
      ST_ERROR  = STATE_ERROR
   } lock_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Digit index 0 is the first digit entered (most significant nibble).
   function automatic logic [3:0] code_nibble(input logic [15:0] code, input logic [1:0] idx);
      logic [3:0] nib;
      case (idx)
         2'd0:    nib = code[15:12];
         2'd1:    nib = code[11:8];
         2'd2:    nib = code[7:4];
         default: nib = code[3:0];
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/door_lock_fsm_lock_timer.sv
// rtl/door_lock_fsm_lock_timer.sv - loadable down-counter shared by all lock windows
module lock_timer #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expired
);

   logic [W-1:0] count_q;

   // Loaded with (window - 1); expiry is seen on the edge that ends the window.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else if (i_load) begin
         count_q <= i_load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign o_expired = (count_q == '0);

endmodule

// File: rtl/door_lock_fsm.sv
// rtl/door_lock_fsm.sv - keypad code check, open/error windows and lockout control
module door_lock_fsm
   import door_lock_pkg::*;
#(
   parameter logic [15:0] CODE           = 16'h1234,
   parameter int unsigned OPEN_CYCLES    = 50_000_000,
   parameter int unsigned ERR_CYCLES     = 25_000_000,
   parameter int unsigned LOCKOUT_CYCLES = 250_000_000,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned ENTRY_TIMEOUT  = 100_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_key_valid,
   input  logic [3:0] i_key,
   input  logic       i_relock,
   output logic [2:0] o_state,
   output logic       o_unlock,
   output logic       o_alarm
);

   localparam int unsigned MAX_CYC = max_u(max_u(OPEN_CYCLES, ERR_CYCLES),
                                           max_u(LOCKOUT_CYCLES, ENTRY_TIMEOUT));
   localparam int unsigned TW   = $clog2(MAX_CYC);
   localparam int unsigned FC_W = $clog2(MAX_FAILS + 1);

   localparam logic [TW-1:0]   OPEN_V  = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0]   ERR_V   = TW'(ERR_CYCLES - 1);
   localparam logic [TW-1:0]   LOCK_V  = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0]   ENTRY_V = TW'(ENTRY_TIMEOUT - 1);
   localparam logic [FC_W-1:0] MAX_F   = FC_W'(MAX_FAILS);

   lock_state_e     state_q;
   logic [FC_W-1:0] fail_q;
   logic [FC_W-1:0] fail_d;
   logic            mism_q;
   logic            mism_d;
   logic            unlock_q;
   logic            alarm_q;
   logic            is_clear;
   logic            in_entry;
   logic            lockout_d;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic            tmr_expired;

   always_comb begin
      is_clear  = (i_key >= KEY_CLEAR);
      in_entry  = state_q inside {ST_LOCKED, ST_DIG1, ST_DIG2, ST_DIG3};
      mism_d    = mism_q | (i_key != code_nibble(CODE, state_q[1:0]));
      fail_d    = (fail_q >= MAX_F) ? MAX_F : fail_q + 1'b1;
      lockout_d = (fail_d == MAX_F);
      tmr_load  = i_key_valid && !is_clear && in_entry;
      tmr_val   = ENTRY_V;
      if (state_q == ST_DIG3) begin
         tmr_val = !mism_d ? OPEN_V : (lockout_d ? LOCK_V : ERR_V);
      end
   end

   lock_timer #(.W(TW)) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (tmr_load),
      .i_load_val (tmr_val),
      .o_expired  (tmr_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_LOCKED;
         fail_q   <= '0;
         mism_q   <= 1'b0;
         unlock_q <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_LOCKED, ST_DIG1, ST_DIG2: begin
               if (i_key_valid) begin
                  if (is_clear) begin
                     state_q <= ST_LOCKED;
                     mism_q  <= 1'b0;
                  end else begin
                     state_q <= lock_state_e'(state_q + 3'd1);
                     mism_q  <= mism_d;
                  end
               end else if (state_q != ST_LOCKED && tmr_expired) begin
                  state_q <= ST_LOCKED;
                  mism_q  <= 1'b0;
               end
            end
            ST_DIG3: begin
               if (i_key_valid) begin
                  mism_q <= 1'b0;
                  if (is_clear) begin
                     state_q <= ST_LOCKED;
                  end else if (mism_d) begin
                     state_q <= ST_ERROR;
                     fail_q  <= fail_d;
                     alarm_q <= lockout_d;
                  end else begin
                     state_q  <= ST_OPEN;
                     fail_q   <= '0;
                     unlock_q <= 1'b1;
                  end
               end else if (tmr_expired) begin
                  state_q <= ST_LOCKED;
                  mism_q  <= 1'b0;
               end
            end
            ST_OPEN: begin
               if (i_relock || tmr_expired) begin
                  state_q  <= ST_LOCKED;
                  unlock_q <= 1'b0;
               end
            end
            ST_ERROR: begin
               if (tmr_expired) begin
                  state_q <= ST_LOCKED;
                  alarm_q <= 1'b0;
                  if (alarm_q) fail_q <= '0;
               end
            end
            default: begin
               state_q  <= ST_LOCKED;
               mism_q   <= 1'b0;
               unlock_q <= 1'b0;
               alarm_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_state  = state_q;
   assign o_unlock = unlock_q;
   assign o_alarm  = alarm_q;

endmodule

// File: doc/door_lock_fsm.md
# door_lock_fsm

Control state machine of the door lock. Accepts debounced keypad digits, checks a 4-digit code, times the open and error windows, counts consecutive failures for lockout, and drives the 3-bit lock state consumed by the 7-segment state decoder plus the actuator and alarm outputs.

## Interface
- `CODE`, 16'h1234: four BCD digits, most significant nibble entered first.
- `OPEN_CYCLES`, 50_000_000: cycles the door stays unlocked.
- `ERR_CYCLES`, 25_000_000: cycles the error indication is held.
- `LOCKOUT_CYCLES`, 250_000_000: error hold used once `MAX_FAILS` is reached.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout.
- `ENTRY_TIMEOUT`, 100_000_000: inactivity limit during digit entry.
- `i_clk`, input, 1: single clock; all logic on the rising edge.
- `i_rst`, input, 1: reset, synchronous and active-high.
- `i_key_valid`, input, 1: one-cycle strobe; `i_key` is valid while it is high.
- `i_key`, input, 4: 0–9 are digits; 4'hA–4'hF are CLEAR.
- `i_relock`, input, 1: level, relocks immediately from OPEN.
- `o_state`, output, 3: lock state code, feeds the state decoder.
- `o_unlock`, output, 1: door actuator, high only in OPEN.
- `o_alarm`, output, 1: high during a lockout hold.

## Operation
- State codes:
  - 3'b000 LOCKED
  - 3'b001 DIG1
  - 3'b010 DIG2
  - 3'b011 DIG3
  - 3'b100 OPEN
  - 3'b101 ERROR
  - 3'b110 and 3'b111 are unused; if reached, the next state is LOCKED.
- Digit path: LOCKED → DIG1 → DIG2 → DIG3, advancing one state per valid digit. The 4th digit in DIG3 evaluates the code and moves to OPEN or ERROR.
- Each digit is compared with its `CODE` nibble on entry. A sticky mismatch flag accumulates the result and is cleared on every entry to LOCKED. No digits are stored.
- A wrong digit is never signalled early; evaluation happens only at the 4th digit.
- CLEAR in LOCKED or any DIGn: go to LOCKED, mismatch cleared, fail count unchanged.
- Inactivity: in DIGn with no `i_key_valid` for `ENTRY_TIMEOUT` cycles → LOCKED. This is not counted as a failure.
- Correct code → OPEN, fail count cleared to 0.
- Wrong code → ERROR, fail count incremented, saturating at `MAX_FAILS`.
- ERROR hold length:
  - If the updated fail count equals `MAX_FAILS`, hold `LOCKOUT_CYCLES` with `o_alarm`=1, then reset the fail count to 0.
  - Otherwise hold `ERR_CYCLES`.
  - After the hold, go to LOCKED.
- OPEN: after `OPEN_CYCLES`, or any cycle `i_relock`=1, go to LOCKED.
- Keys in OPEN or ERROR are ignored; the timer is not restarted.
- One shared down-counter, width `$clog2` of the largest cycle parameter. It is loaded on entry to DIGn, OPEN or ERROR, and reloaded on each valid digit.
- Reset values: `o_state`=3'b000, `o_unlock`=0, `o_alarm`=0, fail count 0, mismatch 0, timer 0.

## Timing
- All outputs are registered.
- `i_key_valid` at edge N → `o_state` updated after edge N; visible in cycle N+1.
- `o_unlock` and `o_alarm` change in the same cycle as `o_state`. No glitches; combinational paths from inputs to outputs are forbidden.
- OPEN lasts exactly `OPEN_CYCLES` cycles when `i_relock` stays low. ERROR lasts exactly `ERR_CYCLES` or `LOCKOUT_CYCLES` cycles.
- Entry timeout fires `ENTRY_TIMEOUT` cycles after the last accepted digit.
- Precedence for simultaneous events:
  - `i_rst` over everything.
  - `i_relock` over timer expiry in OPEN.
  - A valid key and entry-timeout expiry in the same cycle: the key wins.
- Reset mid-entry or mid-lockout: next cycle is LOCKED, and fail count and alarm are cleared.
- Back-to-back `i_key_valid` on consecutive cycles: each strobe is accepted.

## Structure
- `door_lock_pkg` holds:
  - state encoding localparams, shared with the state decoder;
  - the CLEAR key threshold constant (4'hA).
- Sub-module `lock_timer`: loadable down-counter with `i_load`, `i_load_val` and `o_expired`, parameterised by width. The FSM and fail counter stay in `door_lock_fsm`.

## Test plan
Sim parameters: `CODE`=16'h1234, `OPEN_CYCLES`=8, `ERR_CYCLES`=4, `LOCKOUT_CYCLES`=12, `MAX_FAILS`=3, `ENTRY_TIMEOUT`=20.
- Keys 1,2,3,4 → `o_state` 001,010,011,100; `o_unlock`=1 for exactly 8 cycles, then 000.
- Keys 1,2,3,5 → 101 for 4 cycles with `o_alarm`=0, then 000.
- Three wrong codes in a row → third ERROR lasts 12 cycles with `o_alarm`=1; a following correct code reaches 100.
- Keys 1,2 then CLEAR (4'hF) → 000, fail count unchanged.
- Keys 1,2 then 20 idle cycles → 000.
- In OPEN, `i_relock` at cycle 3 → 000 the next cycle.
- `i_rst` during lockout → 000, alarm 0, fail count 0.
